// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types for the handshake pipeline-stage registers:
//               occupancy state encoding and the E->M control bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Encoding is chosen so that the state value is also the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_t;

  // Default payload carried between Execute and Memory.
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
  } em_ctrl_t;

  // All-zero bundle: no register write, no memory write, inert result select.
  localparam em_ctrl_t EM_BUBBLE = '0;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
// Module      : pipe_slot
// Description : Asynchronously reset, enable-gated payload register. One
//               instance holds the stage's main entry, another the skid entry.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_slot #(
  parameter int           W       = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Capture d only when enabled; reset forces the bubble value immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : pipe_slot
`default_nettype wire

// File: rtl/pipe_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_stage
// Description : Handshake pipeline-stage register with stall back-pressure,
//               synchronous flush (bubble insertion) and an optional skid
//               slot that makes in_ready a purely registered signal.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_stage
  import pipe_pkg::*;
#(
  parameter int                DATA_W = $bits(em_ctrl_t),
  parameter logic [DATA_W-1:0] BUBBLE = '0,
  parameter int                SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  pipe_state_t       state;
  pipe_state_t       state_nxt;

  logic              push;
  logic              pop;

  logic              main_en;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] main_q;

  logic              skid_en;
  logic [DATA_W-1:0] skid_d;
  logic [DATA_W-1:0] skid_q;

  // Handshake qualifiers. A flushed cycle never accepts upstream data, but a
  // pop in that cycle is still a completed transfer from the consumer's view.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready;

  // Everything visible downstream is decoded from registered state only.
  assign out_valid = (state != ST_EMPTY);
  assign out_data  = out_valid ? main_q : BUBBLE;
  assign occupancy = state;

  // Ready decode: the skid variant advertises room from state alone; the
  // single-entry variant may accept while its entry is being popped.
  generate
    if (SKID != 0) begin : g_ready_skid
      assign in_ready = (state != ST_TWO);
    end else begin : g_ready_direct
      assign in_ready = (state == ST_EMPTY) || out_ready;
    end
  endgenerate

  // Occupancy state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and slot-write decode; flush overrides any push/pop update.
  always_comb begin
    state_nxt = state;
    main_en   = 1'b0;
    main_d    = in_data;
    skid_en   = 1'b0;
    skid_d    = in_data;

    if (flush) begin
      state_nxt = ST_EMPTY;
      main_en   = 1'b1;
      main_d    = BUBBLE;
      skid_en   = 1'b1;
      skid_d    = BUBBLE;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (push) begin
            state_nxt = ST_ONE;
            main_en   = 1'b1;
          end
        end

        ST_ONE: begin
          if (push && pop) begin
            // Head leaves while a new entry arrives: replace in place.
            main_en = 1'b1;
          end else if (push) begin
            // Only reachable with a skid slot; the single-entry variant
            // deasserts in_ready whenever out_ready is low in ONE.
            if (SKID != 0) begin
              state_nxt = ST_TWO;
              skid_en   = 1'b1;
            end
          end else if (pop) begin
            state_nxt = ST_EMPTY;
            main_en   = 1'b1;
            main_d    = BUBBLE;
          end
        end

        ST_TWO: begin
          // in_ready is low here, so only a pop can move the state.
          if (pop) begin
            state_nxt = ST_ONE;
            main_en   = 1'b1;
            main_d    = skid_q;
            skid_en   = 1'b1;
            skid_d    = BUBBLE;
          end
        end

        default: begin
          // Unused encoding: recover to a clean empty stage.
          state_nxt = ST_EMPTY;
          main_en   = 1'b1;
          main_d    = BUBBLE;
          skid_en   = 1'b1;
          skid_d    = BUBBLE;
        end
      endcase
    end
  end

  pipe_slot #(
    .W       (DATA_W),
    .RST_VAL (BUBBLE)
  ) u_main_slot (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .d   (main_d),
    .q   (main_q)
  );

  generate
    if (SKID != 0) begin : g_skid_slot
      pipe_slot #(
        .W       (DATA_W),
        .RST_VAL (BUBBLE)
      ) u_skid_slot (
        .clk (clk),
        .rst (rst),
        .en  (skid_en),
        .d   (skid_d),
        .q   (skid_q)
      );
    end else begin : g_no_skid
      // No second entry exists; the refill source is never selected.
      assign skid_q = BUBBLE;
    end
  endgenerate

endmodule : pipe_ctrl_stage
`default_nettype wire
